// File: rtl/mux_2_arbiter.sv
// Purpose : round-robin owner of a shared 2:1 data mux feeding one valid/ready sink.
// Latency : grant one edge after a request in IDLE; then one beat per cycle, zero-bubble switch-over.
// Backpres: out_ready low stalls the owner's beat; the grant and beat count hold until it is accepted.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   req_0/data_0/ack_0    - requester 0: beat request, beat data, beat accepted this cycle
//   req_1/data_1/ack_1    - requester 1: same as requester 0
//   out_valid/out_data    - beat towards the sink; out_data is always the mux output
//   out_ready             - sink accepts the beat this cycle
//   select                - registered mux select (1 = requester 1)
//   busy                  - a grant is held
//
// Build option: define MUX_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST accepted
// beats. Without it MAX_BURST is ignored and the owner keeps the mux until its
// request drops.
module mux_2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic [WIDTH-1:0] data_0,
    output logic             ack_0,
    input  logic             req_1,
    input  logic [WIDTH-1:0] data_1,
    output logic             ack_1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             select,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_0 = 2'd1,
        OWN_1 = 2'd2
    } state_t;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_t     state;
    state_t     state_nxt;
    logic       select_nxt;
    logic       last;
    logic       last_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    logic       own_id;     // which requester the current OWN state belongs to
    logic       own_req;
    logic       other_req;
    logic       accept;     // owner's beat accepted this cycle
    logic       limit_hit;  // this acceptance completes the burst
    logic [7:0] cnt_inc;
    logic       release_grant;

    assign own_id    = (state == OWN_1);
    assign own_req   = own_id ? req_1 : req_0;
    assign other_req = own_id ? req_0 : req_1;
    assign accept    = (state != IDLE) && own_req && out_ready;

`ifdef MUX_ARB_BURST_LIMIT_EN
    // cnt only ever reaches MAX_BURST-1 before the grant is recycled, so no wrap.
    assign limit_hit = accept && ((cnt + 8'd1) == MAX_BURST_C);
    assign cnt_inc   = cnt + 8'd1;
`else
    logic unused_max_burst;
    assign unused_max_burst = ^MAX_BURST_C;
    assign limit_hit = 1'b0;
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
`endif

    assign release_grant = !own_req || limit_hit;

    // Outputs are decoded from the registered state so reset clears them at once.
    assign ack_0     = (state == OWN_0) && req_0 && out_ready;
    assign ack_1     = (state == OWN_1) && req_1 && out_ready;
    assign out_valid = ((state == OWN_0) && req_0) || ((state == OWN_1) && req_1);
    assign busy      = (state != IDLE);
    assign out_data  = select ? data_1 : data_0;

    always_comb begin
        state_nxt  = state;
        select_nxt = select;
        last_nxt   = last;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                // On a tie, requester 0 wins only if requester 1 was served last.
                if (req_0 && (!req_1 || last)) begin
                    state_nxt  = OWN_0;
                    select_nxt = 1'b0;
                    last_nxt   = 1'b0;
                    cnt_nxt    = 8'd0;
                end else if (req_1) begin
                    state_nxt  = OWN_1;
                    select_nxt = 1'b1;
                    last_nxt   = 1'b1;
                    cnt_nxt    = 8'd0;
                end
            end
            OWN_0, OWN_1: begin
                if (release_grant) begin
                    if (other_req) begin
                        // Hand straight over to the waiting side, no IDLE bubble.
                        state_nxt  = own_id ? OWN_0 : OWN_1;
                        select_nxt = ~own_id;
                        last_nxt   = ~own_id;
                        cnt_nxt    = 8'd0;
                    end else if (own_req) begin
                        // Burst limit hit with nobody waiting: start a fresh burst.
                        cnt_nxt = 8'd0;
                    end else begin
                        // Select keeps its value through IDLE.
                        state_nxt = IDLE;
                    end
                end else if (accept) begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            select <= 1'b0;
            last   <= 1'b1;
            cnt    <= 8'd0;
        end else begin
            state  <= state_nxt;
            select <= select_nxt;
            last   <= last_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_2_arbiter.sv
// Directed bench for mux_2_arbiter: reset state, tie-break, burst/hold behaviour,
// stall on out_ready, drop-without-ack hand-over and asynchronous reset mid-grant.
// Expectations follow the build option MUX_ARB_BURST_LIMIT_EN where it matters.
module tb_mux_2_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             reset;
    logic             req_0;
    logic [WIDTH-1:0] data_0;
    logic             ack_0;
    logic             req_1;
    logic [WIDTH-1:0] data_1;
    logic             ack_1;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             select;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    mux_2_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .data_0    (data_0),
        .ack_0     (ack_0),
        .req_1     (req_1),
        .data_1    (data_1),
        .ack_1     (ack_1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .select    (select),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every observable output against one expected vector.
    task automatic chk_all(input string tag, input logic e_sel, input logic e_busy,
                           input logic e_vld, input logic e_a0, input logic e_a1);
        chk({tag, ".select"},    32'(select),    32'(e_sel));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
        chk({tag, ".ack_0"},     32'(ack_0),     32'(e_a0));
        chk({tag, ".ack_1"},     32'(ack_1),     32'(e_a1));
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_0     = 1'b0;
        req_1     = 1'b0;
        data_0    = 8'h11;
        data_1    = 8'h22;
        out_ready = 1'b1;
        tick();
        tick();
        chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Idle with no requests for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Simultaneous requests from IDLE: grant must wait one edge, then go to requester 0.
        req_0 = 1'b1;
        req_1 = 1'b1;
        #1;
        chk_all("tie_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef MUX_ARB_BURST_LIMIT_EN
        // Four beats of requester 0, four of requester 1, back to requester 0.
        for (int i = 0; i < 2 * MAX_BURST; i++) begin
            logic own;
            own = ((i / MAX_BURST) % 2) == 1;
            chk_all($sformatf("burst%0d", i), own, 1'b1, 1'b1, !own, own);
            chk($sformatf("burst%0d.data", i), 32'(out_data), own ? 32'h22 : 32'h11);
            tick();
        end
`else
        // No limit: requester 0 keeps the mux while it keeps requesting.
        for (int i = 0; i < 10; i++) begin
            chk_all($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            chk($sformatf("hold%0d.data", i), 32'(out_data), 32'h11);
            tick();
        end
`endif
        // Requester 0 back in charge; it withdraws without an ack while 1 waits.
        chk_all("alt0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        req_0 = 1'b0;
        #1;
        chk_all("drop0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("handover1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("handover1.data", 32'(out_data), 32'h22);

        // Requester 1 finishes; select must hold at 1 in IDLE and out_data still follows it.
        req_1 = 1'b0;
        #1;
        chk_all("drop1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("idle_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_after.data", 32'(out_data), 32'h22);

        // Lone requester 1 with a stall in the middle.
        data_1 = 8'hA5;
        req_1  = 1'b1;
        tick();
        chk_all("stall_b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("stall_b1.data", 32'(out_data), 32'hA5);
        tick();
        out_ready = 1'b0;
        #1;
        chk_all("stall_wait", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_wait.data", 32'(out_data), 32'hA5);
        tick();
        out_ready = 1'b1;
        #1;
        chk_all("stall_b2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        // Two beats taken; hold with the sink stalled, then reset mid-grant.
        out_ready = 1'b0;
        req_0     = 1'b1;
        data_0    = 8'h3C;
        #1;
        chk_all("pre_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk_all("pre_reset_rdy", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_reset.data", 32'(out_data), 32'h3C);
        tick();
        chk_all("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Both still requesting: first grant after reset is requester 0.
        tick();
        chk_all("post_reset_tie", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("post_reset_tie.data", 32'(out_data), 32'h3C);

        req_0 = 1'b0;
        req_1 = 1'b0;
        tick();
        tick();
        chk_all("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_2_arbiter.md
# mux_2_arbiter

Round-robin controller that shares one 2-to-1 data mux and a single downstream sink between two requesters. It owns the mux `select` line, grants one requester at a time, and passes beats to the sink with a valid/ready handshake. An optional burst limit bounds how long one requester can hold the mux.

## Interface
- `WIDTH`, 8, data width of each requester and of the output
- `MAX_BURST`, 4, maximum accepted beats per grant; legal range 1..255; used only when `MUX_ARB_BURST_LIMIT_EN` is defined
- `clk` input 1: single clock, rising-edge active
- `reset` input 1: asynchronous, active-high reset
- `req_0` input 1: requester 0 has a beat on `data_0`; held until `ack_0`
- `data_0` input WIDTH: requester 0 beat data
- `ack_0` output 1: requester 0 beat accepted this cycle
- `req_1` input 1: requester 1 has a beat on `data_1`; held until `ack_1`
- `data_1` input WIDTH: requester 1 beat data
- `ack_1` output 1: requester 1 beat accepted this cycle
- `out_valid` output 1: `out_data` holds a valid beat
- `out_data` output WIDTH: muxed data, `select ? data_1 : data_0`
- `out_ready` input 1: sink accepts the beat this cycle
- `select` output 1: mux select, 1 = requester 1 (registered)
- `busy` output 1: a grant is held (state is not IDLE)

## Operation
- States: IDLE, OWN_0, OWN_1. Internal state: `last` (1 bit, last served requester) and `cnt` (8 bits, beats accepted in the current grant).
- Reset values: state IDLE, `select`=0, `last`=1, `cnt`=0. Outputs during reset: `ack_0`=`ack_1`=`out_valid`=`busy`=0.
- In IDLE:
  - If only `req_x` is high, go to OWN_x.
  - If both are high, go to OWN of the requester not equal to `last`. After reset this is requester 0.
  - On entering OWN_x: `select`<=x, `last`<=x, `cnt`<=0.
- In OWN_x (combinational outputs):
  - `out_valid` = `req_x`
  - `ack_x` = `req_x & out_ready`
  - other ack = 0
- Beat accepted means `ack_x`. On each accepted beat, `cnt` increments.
- Release from OWN_x happens at the clock edge when either condition holds:
  - `req_x` is low, or
  - a beat is accepted with `cnt+1 == MAX_BURST` (limit enabled only).
- Next state on release:
  - Other `req` high: go to OWN_other and update `select`/`last`/`cnt` as above. No IDLE cycle.
  - Else, `req_x` still high (limit hit): stay OWN_x with `cnt`<=0.
  - Else: go to IDLE. `select` holds its value.
- Without release, OWN_x holds and `select` is stable.
- `out_data` is always the mux output, including in IDLE. The sink ignores it while `out_valid`=0.
- `cnt` never exceeds `MAX_BURST`. With the limit disabled, `cnt` saturates at 255.

## Timing
- Grant latency: `req_x` rising in IDLE gives `select`/`busy` one edge later. `out_valid` is asserted in that same cycle.
- Minimum beat rate: one beat per cycle while owning with `out_ready` held high.
- Switch-over: the last beat of OWN_0 is accepted in cycle n and `req_1` is pending. Then OWN_1 is active with `select`=1 in cycle n+1, with zero bubble cycles.
- Simultaneous `req_0`/`req_1` rising in IDLE: tie resolved by `last` as described in Operation.
- `out_ready` low: beat stalls, `cnt` is unchanged, and the grant is held while `req_x` stays high.
- A requester dropping `req_x` without ack is legal. The grant is released at the next edge.
- `reset` asserted mid-grant: state, `select` and `cnt` clear immediately (asynchronously). Acks and `out_valid` drop in the same cycle.

## Configuration
- `MUX_ARB_BURST_LIMIT_EN` defined:
  - `MAX_BURST` is enforced.
  - A requester is preempted after `MAX_BURST` accepted beats if the other requester is waiting.
- Not defined:
  - No burst limit; the owner holds the mux until its `req` drops.
  - `MAX_BURST` is ignored.
  - Tie-breaking in IDLE is still round-robin.

## Test plan
- Reset release, both requests low for 3 cycles -> `select`=0, `busy`=0, `out_valid`=0, no acks.
- `req_0`=`req_1`=1 from IDLE after reset, `out_ready`=1, `data_0`=0x11, `data_1`=0x22, limit on, MAX_BURST=4 -> 4 beats of 0x11 with `ack_0`, then immediately 4 beats of 0x22 with `select`=1, alternating thereafter.
- Only `req_1`=1, `data_1`=0xA5, `out_ready` toggling 1,0,1 -> `ack_1` only in ready cycles, `out_data`=0xA5, grant held through the stall, `cnt` reaches 2.
- Limit off, `req_0` held 10 cycles with `req_1` also high -> 10 consecutive `ack_0` before `select` switches to 1.
- `reset` pulsed mid OWN_1 with `cnt`=2 -> `select`=0, `busy`=0, `ack_1`=0 in the same cycle; first grant after reset goes to requester 0 on a tie.
- `req_0` dropped without ack while `req_1` is waiting -> OWN_1 on the next edge, `ack_0` never asserted.
